// File: rtl/reg_reader.sv
// reg_reader: sweeps a window of register numbers up or down from START and sums the read data.
module reg_reader #(
  parameter int WIDTH = 32,
  parameter int START = 8,
  parameter int COUNT = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             direction,
  input  logic [WIDTH-1:0] rdata,
  output logic [4:0]       regnum,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;
  localparam logic [4:0] START5 = 5'(START);
  localparam logic [4:0] LAST = 5'(COUNT - 1);
  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic dir_q, dir_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    dir_d = dir_q;
    sum_d = sum_q;
    if (state_q == S_READ) begin
      sum_d = sum_q + rdata;
      if (idx_q == LAST) state_d = S_DONE;
      else idx_d = idx_q + 5'd1;
    end else if (go) begin
      state_d = S_READ;
      dir_d = direction;
      idx_d = '0;
      sum_d = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      dir_q <= 1'b0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      dir_q <= dir_d;
      sum_q <= sum_d;
    end
  end
  // 5-bit arithmetic gives the modulo-32 wrap of the register number
  assign regnum = state_q != S_READ ? 5'd0 : dir_q ? START5 + idx_q : START5 - idx_q;
  assign busy = state_q == S_READ;
  assign done = state_q == S_DONE;
  assign sum = sum_q;
endmodule

// File: tb/tb_reg_reader.sv
// tb_reg_reader: directed checks of reg_reader against hand-computed sweep results.
module tb_reg_reader;
  logic clock = 1'b0, reset = 1'b1, go = 1'b0, direction = 1'b0, all_ones = 1'b0;
  logic go2 = 1'b0, dir2 = 1'b0;
  logic [31:0] rdata, rdata2, sum, sum2;
  logic [4:0] regnum, regnum2;
  logic busy, done, busy2, done2;
  int tests = 0, fails = 0;
  always #5 clock = ~clock;
  assign rdata = all_ones ? 32'hFFFF_FFFF : 32'(regnum) * 2 + 1;
  assign rdata2 = 32'(regnum2) * 2 + 1;
  reg_reader dut (.clock(clock), .reset(reset), .go(go), .direction(direction), .rdata(rdata),
    .regnum(regnum), .busy(busy), .done(done), .sum(sum));
  reg_reader #(.WIDTH(32), .START(2), .COUNT(4)) dut2 (.clock(clock), .reset(reset), .go(go2),
    .direction(dir2), .rdata(rdata2), .regnum(regnum2), .busy(busy2), .done(done2), .sum(sum2));
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sweep(input logic d, input logic [31:0] exp_sum, input logic glitch);
    go = 1'b1;
    direction = d;
    tick();
    go = 1'b0;
    chk("sum_cleared", sum, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("regnum%0d", k), 32'(regnum), d ? 32'(8 + k) : 32'(8 - k));
      chk("busy_read", 32'(busy), 32'd1);
      chk("done_read", 32'(done), 32'd0);
      if (glitch && k == 2) begin
        go = 1'b1;
        direction = ~d;
      end
      tick();
      go = 1'b0;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("regnum_done", 32'(regnum), 32'd0);
    chk("sum", sum, exp_sum);
    tick();
    chk("done_hold", 32'(done), 32'd1);
    chk("sum_hold", sum, exp_sum);
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_regnum", 32'(regnum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'd0);
    sweep(1'b0, 32'd65, 1'b0);
    sweep(1'b1, 32'd105, 1'b0);
    all_ones = 1'b1;
    sweep(1'b1, 32'hFFFF_FFFB, 1'b0);
    all_ones = 1'b0;
    sweep(1'b1, 32'd105, 1'b1);
    go = 1'b1;
    direction = 1'b0;
    tick();
    go = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_regnum", 32'(regnum), 32'd0);
    tick();
    chk("idle_stays", 32'(busy), 32'd0);
    sweep(1'b0, 32'd65, 1'b0);
    go = 1'b1;
    direction = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_sum", sum, 32'd105);
    tick();
    chk("b2b_done_one", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_cleared", sum, 32'd0);
    go = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("b2b_sum2", sum, 32'd105);
    go2 = 1'b1;
    dir2 = 1'b0;
    tick();
    go2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_regnum%0d", k), 32'(regnum2), k == 3 ? 32'd31 : 32'(2 - k));
      tick();
    end
    chk("wrap_done", 32'(done2), 32'd1);
    chk("wrap_sum", sum2, 32'd72);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_reader.md
# reg_reader

Read-side sequencer that pairs with the register-writing FSM in the lab datapath. On `go` it sweeps a fixed window of register numbers, either upward or downward from a start register, and drives them onto the register file's read port. It accumulates the returned read data into a running sum and asserts `done` with a stable result. It sits beside the register file and consumes its combinational read port (`regnum` in, `rdata` out).

## Interface
- `WIDTH`, default 32: data width of `rdata` and `sum`.
- `START`, default 8: first register number read in every sweep.
- `COUNT`, default 5: number of registers read per sweep (1..31).

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  start request, sampled on the rising edge.
- `direction`  in  1  sampled with `go`: 1 = ascending (START, START+1, …), 0 = descending (START, START-1, …).
- `rdata`  in  WIDTH  register file read data for the current `regnum`, same cycle (combinational read).
- `regnum`  out  5  register number presented to the read port.
- `busy`  out  1  high while the sweep is in progress.
- `done`  out  1  high while the result is held.
- `sum`  out  WIDTH  accumulated total of the current or last sweep.

## Operation
- Three-state FSM: IDLE, READ, DONE. A 5-bit index counter and a latched direction bit sit beside it.
- Reset forces IDLE. In reset, index = 0, direction latch = 0, `sum` = 0, `regnum` = 0, `busy` = 0, `done` = 0.
- IDLE:
  - `regnum` = 0; `rdata` is ignored.
  - `go`=1 → READ: latch `direction`, index ← 0, `sum` ← 0.
  - `go`=0 → stay in IDLE.
- READ:
  - `busy` = 1.
  - `regnum` = START + index (ascending) or START − index (descending), taken modulo 32 (5-bit wrap).
  - Every edge: `sum` ← `sum` + `rdata`, truncated to WIDTH bits (modulo 2^WIDTH, no saturation, no carry out).
  - If index = COUNT−1 → DONE. Otherwise index ← index+1.
  - `go` and `direction` are ignored throughout READ.
- DONE:
  - `done` = 1, `busy` = 0, `regnum` = 0, `sum` held.
  - `go`=1 → READ, with a new direction latch, index ← 0, `sum` ← 0.
  - `go`=0 → stay in DONE.
- `busy` and `done` are decoded from state and are never high together.
- `reset` wins over every other input in every state, including mid-sweep. The partial sum is discarded and the FSM returns to IDLE on that edge.

## Timing
- `go` sampled high at edge E0 → READ occupies the cycles after edges E0..E(COUNT−1).
- `regnum` shows read k (k = 0..COUNT−1) during the cycle following edge Ek.
- `rdata` is added at the end of that cycle (edge Ek+1).
- `done` rises after edge E(COUNT). With defaults this is 5 cycles after the `go` edge. `sum` is final at that same point.
- `go` held high continuously: back-to-back sweeps, with DONE lasting exactly one cycle between them.
- `regnum`, `busy` and `done` are functions of registered state only. There is no combinational path from `go` to any output.
- `sum` is registered; it changes only on edges in READ, on reset, or on the start edge (cleared).

## Test plan
- Reset, then `go`=1 with `direction`=0, model `rdata` = 2·regnum+1 → `regnum` sequence 8,7,6,5,4 → `done`=1 with `sum` = 65 (0x41) five cycles after the `go` edge.
- From DONE, `go`=1 with `direction`=1, same model → `regnum` 8,9,10,11,12 → `sum` = 105 (0x69); the previous 65 is cleared on the start edge.
- `rdata` = 0xFFFFFFFF on every read, WIDTH=32 → `sum` = 0xFFFFFFFB (modulo wrap).
- `go` pulsed again and `direction` toggled during READ (third cycle) → sequence and `sum` unchanged, `done` after exactly 5 reads.
- `reset` asserted on the third READ cycle → next cycle IDLE, `sum`=0, `regnum`=0, `busy`=0, `done`=0; a following `go` runs a clean sweep.
- START=2, COUNT=4, `direction`=0 → `regnum` 2,1,0,31 (5-bit wrap), `done` after 4 reads.
